// File: rtl/alu_writeback.sv
// ALU result writeback sequencer: splits wide (MULT/DIV) results into two register-file writes.
// Optional build macro ALU_WB_FLAGS_EN enables the architectural status flag register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no write in progress, ready for a result
// ST_WR_LO | writing captured low half to captured dest
// ST_WR_HI | writing captured high half to R0_ADDR
module alu_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter logic [ADDR_W-1:0] R0_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] result,
    input  logic                wide,
    input  logic [ADDR_W-1:0]   dest,
    input  logic                stat_zero,
    input  logic                stat_sign,
    input  logic                stat_overflow,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [2:0]          flags
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WR_LO = 2'd1;
    localparam logic [1:0] ST_WR_HI = 2'd2;

    logic [1:0]        state;
    logic              cap_wide;
    logic [DATA_W-1:0] cap_hi;
    logic              xfer;

    // Only the low phase of a wide result stalls the producer.
    assign in_ready = !((state == ST_WR_LO) && cap_wide);
    assign xfer     = in_valid && in_ready;

    // Write port is registered so it holds its last address/data while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cap_wide <= 1'b0;
            cap_hi   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (xfer) begin
            state    <= ST_WR_LO;
            cap_wide <= wide;
            cap_hi   <= result[2*DATA_W-1:DATA_W];
            rf_we    <= 1'b1;
            rf_waddr <= dest;
            rf_wdata <= result[DATA_W-1:0];
        end else if ((state == ST_WR_LO) && cap_wide) begin
            state    <= ST_WR_HI;
            rf_we    <= 1'b1;
            rf_waddr <= R0_ADDR;
            rf_wdata <= cap_hi;
        end else begin
            state    <= ST_IDLE;
            rf_we    <= 1'b0;
        end
    end

`ifdef ALU_WB_FLAGS_EN
    logic [2:0] cap_stat;
    logic [2:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_stat <= 3'b000;
        end else if (xfer) begin
            cap_stat <= {stat_overflow, stat_sign, stat_zero};
        end
    end

    // Flags commit when the low-half write retires and stay put through WR_HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (state == ST_WR_LO) begin
            flags_q <= cap_stat;
        end
    end

    assign flags = flags_q;
`else
    logic unused_stat;

    assign unused_stat = ^{stat_overflow, stat_sign, stat_zero};
    assign flags       = 3'b000;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; honours ALU_WB_FLAGS_EN when defined.
`timescale 1ns/1ps
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        wide;
    logic [3:0]  dest;
    logic        stat_zero;
    logic        stat_sign;
    logic        stat_overflow;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [2:0]  flags;

    int errors = 0;
    int checks = 0;

    // {rf_we, rf_waddr, rf_wdata, in_ready}
    logic [21:0] obs;
    assign obs = {rf_we, rf_waddr, rf_wdata, in_ready};

    alu_writeback #(.DATA_W(16), .ADDR_W(4), .R0_ADDR(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .wide(wide), .dest(dest),
        .stat_zero(stat_zero), .stat_sign(stat_sign), .stat_overflow(stat_overflow),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic w,
                         input logic [3:0] d, input logic [2:0] st);
        in_valid = v;
        result   = r;
        wide     = w;
        dest     = d;
        {stat_overflow, stat_sign, stat_zero} = st;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        result   = 'x;
        wide     = 1'b0;
        dest     = 4'd0;
        {stat_overflow, stat_sign, stat_zero} = 3'b000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if (obs !== {1'b0, 4'd0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, {1'b0, 4'd0, 16'h0000, 1'b1});
        end
        checks++;
        if (flags !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: got ready=%b we=%b expected ready=1 we=0", in_ready, rf_we);
        end
    endtask

    task automatic test_narrow();
        drive(1'b1, 32'h0000_0005, 1'b0, 4'd3, 3'b000);
        tick();
        idle_inputs();
        checks++;
        if (obs !== {1'b1, 4'd3, 16'h0005, 1'b1}) begin
            errors++;
            $display("FAIL narrow_write: got %h expected %h", obs, {1'b1, 4'd3, 16'h0005, 1'b1});
        end
        tick();
        checks++;
        if (obs !== {1'b0, 4'd3, 16'h0005, 1'b1}) begin
            errors++;
            $display("FAIL narrow_idle_hold: got %h expected %h", obs, {1'b0, 4'd3, 16'h0005, 1'b1});
        end
    endtask

    task automatic test_wide_mult();
        drive(1'b1, 32'h0002_8000, 1'b1, 4'd5, 3'b000);
        tick();
        // keep offering a narrow result while stalled; it must wait for WR_HI
        drive(1'b1, 32'h1111_2222, 1'b0, 4'd7, 3'b000);
        checks++;
        if (obs !== {1'b1, 4'd5, 16'h8000, 1'b0}) begin
            errors++;
            $display("FAIL mult_lo: got %h expected %h", obs, {1'b1, 4'd5, 16'h8000, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {1'b1, 4'd0, 16'h0002, 1'b1}) begin
            errors++;
            $display("FAIL mult_hi: got %h expected %h", obs, {1'b1, 4'd0, 16'h0002, 1'b1});
        end
        tick();
        idle_inputs();
        checks++;
        if (obs !== {1'b1, 4'd7, 16'h2222, 1'b1}) begin
            errors++;
            $display("FAIL mult_stalled_next: got %h expected %h", obs, {1'b1, 4'd7, 16'h2222, 1'b1});
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL mult_drain: got we=%b expected 0", rf_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data [3];
        exp_data[0] = 16'h0011;
        exp_data[1] = 16'h0022;
        exp_data[2] = 16'h0033;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {16'h0, exp_data[i]}, 1'b0, 4'(i + 1), 3'b000);
            tick();
            checks++;
            if (obs !== {1'b1, 4'(i + 1), exp_data[i], 1'b1}) begin
                errors++;
                $display("FAIL b2b_write%0d: got %h expected %h", i, obs, {1'b1, 4'(i + 1), exp_data[i], 1'b1});
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got we=%b expected 0", rf_we);
        end
    endtask

    task automatic test_div_r0();
        drive(1'b1, 32'h0001_0007, 1'b1, 4'd0, 3'b000);
        tick();
        idle_inputs();
        checks++;
        if (obs !== {1'b1, 4'd0, 16'h0007, 1'b0}) begin
            errors++;
            $display("FAIL div_quotient: got %h expected %h", obs, {1'b1, 4'd0, 16'h0007, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {1'b1, 4'd0, 16'h0001, 1'b1}) begin
            errors++;
            $display("FAIL div_remainder: got %h expected %h", obs, {1'b1, 4'd0, 16'h0001, 1'b1});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h0009_0004, 1'b1, 4'd6, 3'b000);
        tick();
        idle_inputs();
        checks++;
        if (obs !== {1'b1, 4'd6, 16'h0004, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_lo: got %h expected %h", obs, {1'b1, 4'd6, 16'h0004, 1'b0});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b0, 4'd0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async: got %h expected %h", obs, {1'b0, 4'd0, 16'h0000, 1'b1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b0, 4'd0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_no_hi: got %h expected %h", obs, {1'b0, 4'd0, 16'h0000, 1'b1});
        end
    endtask

    task automatic test_flags();
        logic [2:0] exp_f1;
        logic [2:0] exp_f2;
`ifdef ALU_WB_FLAGS_EN
        exp_f1 = 3'b001;
        exp_f2 = 3'b100;
`else
        exp_f1 = 3'b000;
        exp_f2 = 3'b000;
`endif
        drive(1'b1, 32'h0000_0000, 1'b0, 4'd2, 3'b001);
        tick();
        idle_inputs();
        checks++;
        if (flags !== 3'b000 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL flags_during_write: got flags=%b we=%b expected 000 1", flags, rf_we);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (flags !== exp_f1) begin
                errors++;
                $display("FAIL flags_zero_hold%0d: got %b expected %b", i, flags, exp_f1);
            end
        end
        drive(1'b1, 32'h0003_0004, 1'b1, 4'd4, 3'b100);
        tick();
        idle_inputs();
        checks++;
        if (flags !== exp_f1) begin
            errors++;
            $display("FAIL flags_wide_lo: got %b expected %b", flags, exp_f1);
        end
        tick();
        checks++;
        if (flags !== exp_f2 || rf_waddr !== 4'd0 || rf_wdata !== 16'h0003) begin
            errors++;
            $display("FAIL flags_wide_hi: got flags=%b addr=%h data=%h expected %b 0 0003", flags, rf_waddr, rf_wdata, exp_f2);
        end
        tick();
        checks++;
        if (flags !== exp_f2 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL flags_wide_idle: got flags=%b we=%b expected %b 0", flags, rf_we, exp_f2);
        end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide_mult();
        test_back_to_back();
        test_div_r0();
        test_reset_mid();
        test_flags();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish before 20000ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DATA_W, default 16: register-file data width; the ALU result is 2*DATA_W wide.
REQ-002 Parameter ADDR_W, default 4: register-file address width.
REQ-003 Parameter R0_ADDR, default 0: destination of the upper result half (MULT high product, DIV remainder).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  ALU result presented this cycle.
REQ-007 in_ready  output  1  block accepts the presented result this cycle.
REQ-008 result  input  2*DATA_W  ALU output; [DATA_W-1:0] low half, [2*DATA_W-1:DATA_W] high half.
REQ-009 wide  input  1  result needs two writes (MULT/DIV).
REQ-010 dest  input  ADDR_W  destination register for the low half.
REQ-011 stat_zero, stat_sign, stat_overflow  input  1 each  ALU status for this result.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_waddr  output  ADDR_W  register-file write address.
REQ-014 rf_wdata  output  DATA_W  register-file write data.
REQ-015 flags  output  3  architectural status {overflow, sign, zero}.

Function
REQ-016 A transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; all input fields are captured in that transfer.
REQ-017 The FSM SHALL have the states IDLE, WR_LO and WR_HI.
REQ-018 A transfer SHALL move the FSM to WR_LO on the next edge from any state.
REQ-019 In WR_LO: rf_we=1, rf_waddr=captured dest, rf_wdata=captured low half.
REQ-020 In WR_LO, next state: WR_HI if captured wide=1; else WR_LO on a new transfer; else IDLE.
REQ-021 In WR_HI: rf_we=1, rf_waddr=R0_ADDR, rf_wdata=captured high half.
REQ-022 In WR_HI, next state: WR_LO on a new transfer, else IDLE.
REQ-023 In IDLE, rf_we SHALL be 0, and rf_waddr and rf_wdata SHALL hold their last values.
REQ-024 in_ready SHALL be 1 in IDLE and in WR_HI, 1 in WR_LO when captured wide=0, and 0 in WR_LO when captured wide=1.
REQ-025 in_ready SHALL be combinational from state only, never from in_valid.
REQ-026 Latency from transfer to low-half write SHALL be 1 cycle; the high-half write follows in the next cycle.
REQ-027 Sustained throughput SHALL be 1 result per cycle for narrow results and 1 per 2 cycles for wide results.
REQ-028 A wide result with dest=R0_ADDR SHALL write the low half first and then the high half, so the high half is the final R0 value.
REQ-029 Inputs SHALL be ignored when in_valid=0; X/Z on result while in_valid=0 SHALL NOT propagate to any output.
REQ-030 Exactly one register-file write per cycle; no write SHALL be dropped or duplicated.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, flags=0, and all captured fields cleared.
REQ-032 Reset asserted in WR_LO or WR_HI SHALL abandon the pending write(s).
REQ-033 After rst_n deasserts, in_ready SHALL be 1 from the first edge.

Configuration
REQ-034 With macro ALU_WB_FLAGS_EN defined, flags SHALL load the captured {stat_overflow, stat_sign, stat_zero} on the edge that leaves WR_LO, and SHALL hold their value otherwise, including through WR_HI.
REQ-035 Without ALU_WB_FLAGS_EN, flags SHALL be constant 0, and no flag storage SHALL be synthesized.

Verification
REQ-036 Narrow ADD: result=0x0000_0005, dest=3, single transfer -> next cycle rf_we=1, waddr=3, wdata=0x0005; following cycle rf_we=0.
REQ-037 Wide MULT: result=0x0002_8000, dest=5 -> WR_LO writes 0x8000 to reg 5 with in_ready=0; WR_HI writes 0x0002 to reg 0 with in_ready=1.
REQ-038 Back-to-back narrow results to dest 1, 2, 3 on consecutive cycles -> three consecutive writes, in_ready held at 1, no bubbles.
REQ-039 Wide DIV with dest=0 (quotient 0x0007, remainder 0x0001) -> R0 written 0x0007 then 0x0001.
REQ-040 rst_n pulsed low mid-WR_LO of a wide op -> rf_we=0 immediately, no high-half write, state IDLE.
REQ-041 With ALU_WB_FLAGS_EN, SUB result 0 with stat_zero=1 -> flags=3'b001 one cycle after the write, held through idle cycles; without the macro, flags stays 0.
